xor_session_ctrl: RTL and testbench
===================================

Name: xor_session_ctrl

Overview:
Top-level sequencer for the XOR cipher datapath. It frames one serial input stream into key bits and then message bits by driving the key and message deserializers' load flags. It then triggers encryption and serialization, and waits on each stage's completion. It reports busy, done and timeout status and exposes its state for debug. It replaces direct pin-driven load flags, so a host only supplies iStart, bit strobes and data.

Parameters:
KEY_SIZE, 32, key bits per session (>=1).
MSG_SIZE, 512, message bits per session (>=KEY_SIZE).
TIMEOUT_CYCLES, 4096, max cycles allowed in ENCRYPT or SERIALIZE before error (>=2).

Ports:
iClk  in  1  system clock.
iRst  in  1  reset, synchronous, active-high.
iEn  in  1  clock enable; low = freeze.
iStart  in  1  start session; sampled in IDLE or ERROR only.
iAbort  in  1  abort session; return to IDLE.
iBit_valid  in  1  serial data bit present this cycle.
iEncrypt_done  in  1  completion from encryptor.
iSerial_end  in  1  last-bit flag from serializer.
oLoad_key  out  1  key deserializer load flag (combinational).
oLoad_msg  out  1  message deserializer load flag (combinational).
oEncrypt_go  out  1  1-cycle encrypt trigger (registered).
oSerialize_go  out  1  1-cycle serialize trigger (registered).
oBusy  out  1  high in any state except IDLE and ERROR.
oDone  out  1  1-cycle session-complete pulse.
oError  out  1  timeout flag, level.
oState  out  3  encoded state.
oBit_count  out  $clog2(MSG_SIZE)+1  bits accepted in current load phase.

Behaviour:
- State encodings: IDLE=0, LOAD_KEY=1, LOAD_MSG=2, ENCRYPT=3, SERIALIZE=4, DONE=5, ERROR=6. Code 7 is unreachable and maps to IDLE next cycle.
- Reset (iRst=1 at iClk edge, overrides iEn):
  - state IDLE.
  - oBit_count=0, timer=0.
  - oEncrypt_go=0, oSerialize_go=0, oDone=0, oError=0.
- iEn=0 behaviour:
  - state, oBit_count, timer and oError hold.
  - oEncrypt_go, oSerialize_go and oDone are cleared to 0.
  - oLoad_key and oLoad_msg are forced to 0.
- Priority at each enabled edge: iRst > iAbort > normal transitions.
  - iAbort in any state other than IDLE: next state IDLE, oBit_count=0, oError=0, no pulses.
- IDLE:
  - iStart=1 -> LOAD_KEY, oBit_count=0.
  - iBit_valid is ignored.
- LOAD_KEY:
  - oLoad_key = iBit_valid & iEn.
  - Each valid bit increments oBit_count.
  - When the bit with oBit_count==KEY_SIZE-1 is accepted: -> LOAD_MSG, oBit_count=0.
- LOAD_MSG:
  - Same counting as LOAD_KEY, using oLoad_msg.
  - When bit MSG_SIZE-1 is accepted: -> ENCRYPT, timer=0, oEncrypt_go=1 on the next cycle only.
- ENCRYPT:
  - iEncrypt_done=1 -> SERIALIZE, timer=0, oSerialize_go=1 for one cycle.
  - Otherwise timer increments; timer==TIMEOUT_CYCLES-1 -> ERROR.
  - If done and timeout occur in the same cycle, done wins.
  - iEncrypt_done is accepted even in the same cycle oEncrypt_go is high.
- SERIALIZE:
  - iSerial_end=1 -> DONE.
  - Timeout rule is identical to ENCRYPT.
- DONE:
  - oDone=1 for exactly one cycle, then -> IDLE unconditionally.
  - iStart in DONE is ignored.
- ERROR:
  - oError=1, held.
  - iStart -> LOAD_KEY with oError cleared to 0 in the same edge.
  - iAbort -> IDLE with oError cleared.
- Ignored inputs:
  - iStart outside IDLE/ERROR.
  - iEncrypt_done outside ENCRYPT.
  - iSerial_end outside SERIALIZE.
- iBit_valid is ignored outside the load states, and oLoad_* stay 0 there.
- Counter widths: oBit_count never exceeds MSG_SIZE-1. Timer width is $clog2(TIMEOUT_CYCLES), saturating at the terminal compare.
- Latency: iStart to first accepted bit is 1 cycle; last message bit to oEncrypt_go is 1 cycle; iSerial_end to oDone is 1 cycle.

Test Plan:
Bench parameters: KEY_SIZE=4, MSG_SIZE=8, TIMEOUT_CYCLES=16.
1. Nominal session: reset; iStart; 12 consecutive valid bits; iEncrypt_done 3 cycles after go; iSerial_end 5 cycles later -> 4 oLoad_key cycles, then 8 oLoad_msg cycles; exactly one oEncrypt_go, one oSerialize_go and one oDone; state sequence 1,2,3,4,5,0.
2. Gappy bits: iBit_valid toggling 1,0,1,0 through both load phases -> oBit_count advances only on valid cycles; transition to LOAD_MSG only after the 4th key bit.
3. Encrypt timeout: nominal load, iEncrypt_done never asserted -> ERROR 16 cycles after ENCRYPT entry; oError=1 held; a later iStart -> LOAD_KEY with oError=0.
4. Abort and restart: iAbort on the 6th message bit -> IDLE next cycle, oBit_count=0, oBusy=0; then a full nominal session completes correctly.
5. Enable freeze: iEn=0 for 3 cycles mid LOAD_KEY, with iBit_valid=1 -> oLoad_key=0 and oBit_count unchanged; counting resumes when iEn returns to 1.
6. Edge cases:
   - iEncrypt_done coincident with oEncrypt_go -> SERIALIZE next cycle.
   - iEncrypt_done and timeout in the same cycle -> SERIALIZE, not ERROR.
   - iRst asserted in SERIALIZE with iEn=0 -> IDLE, all outputs 0.

Source files
------------

// File: rtl/xor_session_ctrl_if.sv
// Host/datapath handshake bundle for the XOR session sequencer.
interface xor_session_ctrl_if #(
   parameter int MSG_SIZE = 512
);
   localparam int BCW = $clog2(MSG_SIZE) + 1;

   logic           iEn;
   logic           iStart;
   logic           iAbort;
   logic           iBit_valid;
   logic           iEncrypt_done;
   logic           iSerial_end;
   logic           oLoad_key;
   logic           oLoad_msg;
   logic           oEncrypt_go;
   logic           oSerialize_go;
   logic           oBusy;
   logic           oDone;
   logic           oError;
   logic [2:0]     oState;
   logic [BCW-1:0] oBit_count;

   modport slave (
      input  iEn, iStart, iAbort, iBit_valid, iEncrypt_done, iSerial_end,
      output oLoad_key, oLoad_msg, oEncrypt_go, oSerialize_go, oBusy, oDone,
             oError, oState, oBit_count
   );

   modport master (
      output iEn, iStart, iAbort, iBit_valid, iEncrypt_done, iSerial_end,
      input  oLoad_key, oLoad_msg, oEncrypt_go, oSerialize_go, oBusy, oDone,
             oError, oState, oBit_count
   );
endinterface

// File: rtl/xor_session_ctrl.sv
// Session sequencer: frames key then message bits, triggers encrypt and
// serialize, and watches both stages with a shared timeout timer.
module xor_session_ctrl #(
   parameter int KEY_SIZE       = 32,
   parameter int MSG_SIZE       = 512,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic             iClk,
   input logic             iRst,
   xor_session_ctrl_if.slave bus
);
   localparam int BCW = $clog2(MSG_SIZE) + 1;
   localparam int TW  = $clog2(TIMEOUT_CYCLES);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD_KEY  = 3'd1;
   localparam logic [2:0] S_LOAD_MSG  = 3'd2;
   localparam logic [2:0] S_ENCRYPT   = 3'd3;
   localparam logic [2:0] S_SERIALIZE = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;
   localparam logic [2:0] S_ERROR     = 3'd6;

   localparam logic [BCW-1:0] KEY_LAST = BCW'(KEY_SIZE - 1);
   localparam logic [BCW-1:0] MSG_LAST = BCW'(MSG_SIZE - 1);
   localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]     state, state_nx;
   logic [BCW-1:0] cnt, cnt_nx;
   logic [TW-1:0]  tmr, tmr_nx;
   logic           ego, ego_nx, sgo, sgo_nx, done, done_nx, err, err_nx;

   // Next-state decode; abort outranks every normal transition.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tmr_nx   = tmr;
      err_nx   = err;
      ego_nx   = 1'b0;
      sgo_nx   = 1'b0;
      done_nx  = 1'b0;
      if (bus.iAbort && state != S_IDLE) begin
         state_nx = S_IDLE;
         cnt_nx   = '0;
         err_nx   = 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.iStart) begin
               state_nx = S_LOAD_KEY;
               cnt_nx   = '0;
            end
            S_LOAD_KEY: if (bus.iBit_valid) begin
               if (cnt == KEY_LAST) begin
                  state_nx = S_LOAD_MSG;
                  cnt_nx   = '0;
               end else cnt_nx = cnt + 1'b1;
            end
            S_LOAD_MSG: if (bus.iBit_valid) begin
               if (cnt == MSG_LAST) begin
                  state_nx = S_ENCRYPT;
                  cnt_nx   = '0;
                  tmr_nx   = '0;
                  ego_nx   = 1'b1;
               end else cnt_nx = cnt + 1'b1;
            end
            // Completion is checked before the timeout so a late done still wins.
            S_ENCRYPT, S_SERIALIZE: begin
               if (state == S_ENCRYPT && bus.iEncrypt_done) begin
                  state_nx = S_SERIALIZE;
                  tmr_nx   = '0;
                  sgo_nx   = 1'b1;
               end else if (state == S_SERIALIZE && bus.iSerial_end) begin
                  state_nx = S_DONE;
                  done_nx  = 1'b1;
               end else if (tmr == TMR_LAST) begin
                  state_nx = S_ERROR;
                  err_nx   = 1'b1;
               end else tmr_nx = tmr + 1'b1;
            end
            S_DONE: state_nx = S_IDLE;
            S_ERROR: if (bus.iStart) begin
               state_nx = S_LOAD_KEY;
               cnt_nx   = '0;
               err_nx   = 1'b0;
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // State/counter registers; disabled cycles hold state and drop pulses.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= S_IDLE;
         cnt   <= '0;
         tmr   <= '0;
         ego   <= 1'b0;
         sgo   <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else if (!bus.iEn) begin
         ego   <= 1'b0;
         sgo   <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         tmr   <= tmr_nx;
         ego   <= ego_nx;
         sgo   <= sgo_nx;
         done  <= done_nx;
         err   <= err_nx;
      end
   end

   assign bus.oLoad_key     = bus.iEn && bus.iBit_valid && state == S_LOAD_KEY;
   assign bus.oLoad_msg     = bus.iEn && bus.iBit_valid && state == S_LOAD_MSG;
   assign bus.oEncrypt_go   = ego;
   assign bus.oSerialize_go = sgo;
   assign bus.oDone         = done;
   assign bus.oError        = err;
   assign bus.oBusy         = state >= S_LOAD_KEY && state <= S_DONE;
   assign bus.oState        = state;
   assign bus.oBit_count    = cnt;
endmodule

// File: tb/tb_xor_session_ctrl.sv
// Bench for xor_session_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a session-level reference model.
module tb_xor_session_ctrl;
   localparam int KEY = 4, MSG = 8, TO = 16;

   logic iClk = 1'b0;
   logic iRst = 1'b1;
   xor_session_ctrl_if #(.MSG_SIZE(MSG)) bus();
   xor_session_ctrl #(.KEY_SIZE(KEY), .MSG_SIZE(MSG), .TIMEOUT_CYCLES(TO)) dut (
      .iClk(iClk), .iRst(iRst), .bus(bus)
   );

   always #5 iClk = ~iClk;

   int vec = 0, miss = 0;
   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      vec++;
      if (act !== 32'(exp)) begin
         miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase code plus total bits taken this session.
   typedef struct {int ph; int bits; int tmr; bit ego; bit sgo; bit dn; bit er;} ms_t;
   ms_t m = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
   bit  armed = 1'b0;

   function automatic ms_t model_next(ms_t s, bit r, bit en, bit st, bit ab,
                                      bit v, bit ed, bit se);
      ms_t n = s;
      n.ego = 1'b0; n.sgo = 1'b0; n.dn = 1'b0;
      if (r) begin n.ph = 0; n.bits = 0; n.tmr = 0; n.er = 1'b0; return n; end
      if (!en) return n;
      if (ab && s.ph != 0) begin n.ph = 0; n.bits = 0; n.er = 1'b0; return n; end
      case (s.ph)
         0: if (st) begin n.ph = 1; n.bits = 0; end
         1, 2: if (v) begin
            n.bits++;
            if (n.bits == KEY) n.ph = 2;
            else if (n.bits == KEY + MSG) begin n.ph = 3; n.tmr = 0; n.ego = 1'b1; end
         end
         3, 4: begin
            if ((s.ph == 3 && ed) || (s.ph == 4 && se)) begin
               n.ph = s.ph + 1; n.tmr = 0;
               if (s.ph == 3) n.sgo = 1'b1; else n.dn = 1'b1;
            end else if (s.tmr == TO - 1) begin n.ph = 6; n.er = 1'b1; end
            else n.tmr++;
         end
         5: n.ph = 0;
         6: if (st) begin n.ph = 1; n.bits = 0; n.er = 1'b0; end
         default: n.ph = 0;
      endcase
      return n;
   endfunction

   initial forever begin
      @(posedge iClk);
      m = model_next(m, iRst, bus.iEn, bus.iStart, bus.iAbort, bus.iBit_valid,
                     bus.iEncrypt_done, bus.iSerial_end);
      if (iRst) armed = 1'b1;
   end

   // Per-cycle compare plus tallies used by the directed scenarios.
   int n_lk = 0, n_lm = 0, n_ego = 0, n_sgo = 0, n_done = 0;
   int stq[$];
   int last_st = 0;
   initial forever begin
      int exp_bc;
      @(negedge iClk);
      if (armed) begin
         exp_bc = (m.ph == 1) ? m.bits : (m.ph == 2) ? m.bits - KEY : 0;
         chk("state", bus.oState, m.ph);
         chk("bit_count", bus.oBit_count, exp_bc);
         chk("load_key", bus.oLoad_key, int'(bus.iEn && bus.iBit_valid && m.ph == 1));
         chk("load_msg", bus.oLoad_msg, int'(bus.iEn && bus.iBit_valid && m.ph == 2));
         chk("encrypt_go", bus.oEncrypt_go, m.ego);
         chk("serialize_go", bus.oSerialize_go, m.sgo);
         chk("done", bus.oDone, m.dn);
         chk("error", bus.oError, m.er);
         chk("busy", bus.oBusy, int'(m.ph >= 1 && m.ph <= 5));
         if (bus.oLoad_key === 1'b1) n_lk++;
         if (bus.oLoad_msg === 1'b1) n_lm++;
         if (bus.oEncrypt_go === 1'b1) n_ego++;
         if (bus.oSerialize_go === 1'b1) n_sgo++;
         if (bus.oDone === 1'b1) n_done++;
         if (int'(bus.oState) != last_st) begin
            last_st = int'(bus.oState);
            stq.push_back(last_st);
         end
      end
   end

   task automatic cyc(bit v = 0, bit s = 0, bit a = 0, bit ed = 0, bit se = 0,
                      bit en = 1, bit r = 0);
      bus.iBit_valid = v; bus.iStart = s; bus.iAbort = a;
      bus.iEncrypt_done = ed; bus.iSerial_end = se; bus.iEn = en; iRst = r;
      @(posedge iClk); #2;
   endtask

   task automatic nominal(int ed_gap, int se_gap);
      cyc(.s(1));
      repeat (KEY + MSG) cyc(.v(1));
      repeat (ed_gap) cyc();
      cyc(.ed(1));
      repeat (se_gap) cyc();
      cyc(.se(1));
      cyc();
      cyc();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
      $fatal(1);
   end

   initial begin
      int b_lk, b_lm, b_ego, b_sgo, b_done, b_q;
      int seq[6] = '{1, 2, 3, 4, 5, 0};
      cyc(.r(1)); cyc(.r(1));
      chk("reset_state", bus.oState, 0);
      chk("reset_count", bus.oBit_count, 0);
      chk("reset_flags", {bus.oEncrypt_go, bus.oSerialize_go, bus.oDone, bus.oError, bus.oBusy}, 0);
      cyc();

      // Nominal session with tallies and state sequence.
      b_lk = n_lk; b_lm = n_lm; b_ego = n_ego; b_sgo = n_sgo; b_done = n_done; b_q = stq.size();
      nominal(3, 5);
      chk("nom_load_key_cycles", n_lk - b_lk, KEY);
      chk("nom_load_msg_cycles", n_lm - b_lm, MSG);
      chk("nom_encrypt_go", n_ego - b_ego, 1);
      chk("nom_serialize_go", n_sgo - b_sgo, 1);
      chk("nom_done", n_done - b_done, 1);
      chk("nom_seq_len", stq.size() - b_q, 6);
      for (int i = 0; i < 6; i++)
         if (b_q + i < stq.size()) chk("nom_seq", stq[b_q + i], seq[i]);

      // Gappy bits, then encrypt timeout.
      cyc(.s(1));
      for (int i = 0; i < 6; i++) cyc(.v(i % 2 == 0));
      chk("gap_key_state", bus.oState, 1);
      chk("gap_key_count", bus.oBit_count, 3);
      cyc(.v(1));
      chk("gap_msg_state", bus.oState, 2);
      chk("gap_msg_count", bus.oBit_count, 0);
      for (int i = 0; i < 15; i++) cyc(.v(i % 2 == 0));
      chk("gap_encrypt_entry", bus.oState, 3);
      repeat (TO - 1) cyc();
      chk("to_still_encrypt", bus.oState, 3);
      cyc();
      chk("to_error_state", bus.oState, 6);
      chk("to_error_flag", bus.oError, 1);
      repeat (3) cyc();
      chk("to_error_held", bus.oError, 1);
      cyc(.s(1));
      chk("err_restart_state", bus.oState, 1);
      chk("err_restart_flag", bus.oError, 0);

      // Abort on the 6th message bit, then a clean session.
      repeat (KEY + 5) cyc(.v(1));
      cyc(.v(1), .a(1));
      chk("abort_state", bus.oState, 0);
      chk("abort_count", bus.oBit_count, 0);
      chk("abort_busy", bus.oBusy, 0);
      b_done = n_done;
      nominal(1, 2);
      chk("abort_rerun_done", n_done - b_done, 1);

      // Enable freeze mid key load, then done coincident with go.
      cyc(.s(1));
      repeat (2) cyc(.v(1));
      repeat (3) cyc(.v(1), .en(0));
      chk("freeze_count", bus.oBit_count, 2);
      chk("freeze_state", bus.oState, 1);
      repeat (2) cyc(.v(1));
      chk("freeze_resume", bus.oState, 2);
      repeat (MSG) cyc(.v(1));
      chk("coinc_go", bus.oEncrypt_go, 1);
      cyc(.ed(1));
      chk("coinc_serialize", bus.oState, 4);
      cyc(.se(1));
      chk("coinc_done", bus.oDone, 1);
      cyc();

      // Done at the terminal timer count wins; reset while frozen in SERIALIZE.
      cyc(.s(1));
      repeat (KEY + MSG) cyc(.v(1));
      repeat (TO - 1) cyc();
      cyc(.ed(1));
      chk("late_done_state", bus.oState, 4);
      chk("late_done_error", bus.oError, 0);
      cyc(.en(0));
      cyc(.en(0), .r(1));
      chk("rst_frozen_state", bus.oState, 0);
      chk("rst_frozen_outs", {bus.oLoad_key, bus.oLoad_msg, bus.oEncrypt_go,
                              bus.oSerialize_go, bus.oBusy, bus.oDone, bus.oError,
                              bus.oBit_count}, 0);
      cyc();

      // Random traffic.
      repeat (3000)
         cyc(.v($urandom_range(9, 0) < 7), .s($urandom_range(7, 0) == 0),
             .a($urandom_range(99, 0) == 0), .ed($urandom_range(9, 0) == 0),
             .se($urandom_range(9, 0) == 0), .en($urandom_range(9, 0) != 0),
             .r($urandom_range(199, 0) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
